bht_predictor: RTL

- Parametrised branch history table for the pipelined RV32I core. Generalises the single-state one-bit predictor into a table of 2^INDEX_BITS saturating counters of CTR_BITS each.
- Optional global-history (gshare) indexing via HIST_BITS.
- Fetch reads a prediction combinationally from the PC. Execute writes back the resolved outcome one update per cycle.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/bht_predictor.sv | 106 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table: counter init,
// saturating step and table index hashing.
package bp_pkg;

    localparam int MAX_CTR_W  = 4;
    localparam int MAX_IDX_W  = 12;
    localparam int MAX_HIST_W = 12;

    typedef logic [MAX_CTR_W-1:0]  ctr_t;
    typedef logic [MAX_IDX_W-1:0]  idx_t;
    typedef logic [MAX_HIST_W-1:0] hist_t;

    function automatic ctr_t weak_nt(input int ctr_bits);
        return ctr_t'((1 << (ctr_bits - 1)) - 1);
    endfunction

    // Saturation is tested before stepping, so the counter never wraps.
    function automatic ctr_t sat_step(input ctr_t val, input logic up, input int ctr_bits);
        ctr_t max_v;
        max_v = ctr_t'((1 << ctr_bits) - 1);
        if (up) begin
            return (val == max_v) ? val : val + 4'd1;
        end
        return (val == '0) ? val : val - 4'd1;
    endfunction

    // Word-aligned PC bits XOR an already zero-extended history.
    function automatic idx_t bht_index(input logic [31:0] pc, input hist_t hist,
                                       input int index_bits);
        idx_t mask;
        idx_t raw;
        mask = idx_t'((1 << index_bits) - 1);
        raw  = idx_t'(pc >> 2);
        return (raw ^ hist) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// One BHT entry: CTR_BITS-wide saturating up/down counter that resets and
// clears to weak-not-taken.
module sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic                dir_i,
    output logic [CTR_BITS-1:0] cnt_o
);

    localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0] cnt_q;
    logic [CTR_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = INIT;
        end else if (en_i) begin
            cnt_d = CTR_BITS'(sat_step(ctr_t'(cnt_q), dir_i, CTR_BITS));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 2^INDEX_BITS saturating counters, bimodal or gshare
// indexed, combinational fetch-side read and one execute-side update per cycle.
module bht_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0,
    localparam int HW        = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [31:0]   pred_pc,
    output logic          predict_taken,
    output logic [HW-1:0] pred_hist,
    input  logic          upd_valid,
    input  logic [31:0]   upd_pc,
    input  logic [HW-1:0] upd_hist,
    input  logic          upd_taken
);

    localparam int    ENTRIES = 1 << INDEX_BITS;
    localparam hist_t HMASK   = (HIST_BITS > 0) ? hist_t'((1 << HIST_BITS) - 1) : '0;

    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
        $error("bht_predictor: CTR_BITS must be in 1..4");
    end
    if (INDEX_BITS < 1 || INDEX_BITS > 12) begin : g_bad_idx
        $error("bht_predictor: INDEX_BITS must be in 1..12");
    end
    if (HIST_BITS < 0 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("bht_predictor: HIST_BITS must be in 0..INDEX_BITS");
    end

    logic [HW-1:0]         ghr_q;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [ENTRIES-1:0]    upd_sel;
    logic [CTR_BITS-1:0]   ctr [ENTRIES];

    // HMASK forces the history term to zero in bimodal mode.
    always_comb begin
        pred_idx = INDEX_BITS'(bht_index(pred_pc, hist_t'(ghr_q) & HMASK, INDEX_BITS));
        upd_idx  = INDEX_BITS'(bht_index(upd_pc, hist_t'(upd_hist) & HMASK, INDEX_BITS));
    end

    always_comb begin
        upd_sel = '0;
        if (upd_valid) begin
            upd_sel[upd_idx] = 1'b1;
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        sat_counter #(
            .CTR_BITS(CTR_BITS)
        ) u_ctr (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .clear_i(clear),
            .en_i   (upd_sel[e]),
            .dir_i  (upd_taken),
            .cnt_o  (ctr[e])
        );
    end

    // No bypass: a same-cycle update is only visible after the edge.
    assign predict_taken = ctr[pred_idx][CTR_BITS-1];
    assign pred_hist     = ghr_q;

    if (HIST_BITS == 0) begin : g_no_ghr
        assign ghr_q = '0;
    end else begin : g_ghr
        logic [HW-1:0] ghr_d;

        if (HIST_BITS == 1) begin : g_shift1
            always_comb begin
                ghr_d = ghr_q;
                if (clear) begin
                    ghr_d = '0;
                end else if (upd_valid) begin
                    ghr_d = upd_taken;
                end
            end
        end else begin : g_shiftn
            always_comb begin
                ghr_d = ghr_q;
                if (clear) begin
                    ghr_d = '0;
                end else if (upd_valid) begin
                    ghr_d = {ghr_q[HW-2:0], upd_taken};
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ghr_q <= '0;
            end else begin
                ghr_q <= ghr_d;
            end
        end
    end

endmodule
